// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus arbiter.
// The payload carried per result is {rob_idx, val, jump_flag, jump_pc}.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC   = 3;
  localparam int CDB_ROB_IDX_W = 4;
  localparam int CDB_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_LSB = 2'd1,
    CDB_SRC_AUX = 2'd2
  } cdb_src_e;

  function automatic int cdb_payload_w(int rob_idx_w);
    return rob_idx_w + 1 + 64;
  endfunction

  localparam int CDB_PAYLOAD_W = cdb_payload_w(CDB_ROB_IDX_W);

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side result ports and the broadcast CDB, bundled as one interface.
// Per-source fields are packed arrays: slice i belongs to source i.
interface cdb_arbiter_if #(
  parameter int NUM_SRC   = 3,
  parameter int ROB_IDX_W = 4
);
  logic [NUM_SRC-1:0]                src_valid;
  logic [NUM_SRC-1:0]                src_ready;
  logic [NUM_SRC-1:0][ROB_IDX_W-1:0] src_ROB_idx;
  logic [NUM_SRC-1:0][31:0]          src_val;
  logic [NUM_SRC-1:0]                src_jump_flag;
  logic [NUM_SRC-1:0][31:0]          src_jump_PC;

  logic                              cdb_flag;
  cdb_arbiter_pkg::cdb_src_e         cdb_src;
  logic [ROB_IDX_W-1:0]              cdb_ROB_idx;
  logic [31:0]                       cdb_val;
  logic                              cdb_jump_flag;
  logic [31:0]                       cdb_jump_PC;

  modport master (
    output src_valid, src_ROB_idx, src_val, src_jump_flag, src_jump_PC,
    input  src_ready,
    input  cdb_flag, cdb_src, cdb_ROB_idx, cdb_val, cdb_jump_flag, cdb_jump_PC
  );

  modport slave (
    input  src_valid, src_ROB_idx, src_val, src_jump_flag, src_jump_PC,
    output src_ready,
    output cdb_flag, cdb_src, cdb_ROB_idx, cdb_val, cdb_jump_flag, cdb_jump_PC
  );
endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// Small per-producer result FIFO; power-of-two depth so pointers wrap freely.
// flush drops every buffered entry in one edge.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok, pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter from per-producer FIFOs onto a registered common data bus.
// A roll flushes everything; rdy low freezes the whole block.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = CDB_NUM_SRC,
  parameter int ROB_IDX_W = CDB_ROB_IDX_W,
  parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         roll,
  cdb_arbiter_if.slave bus
);
  localparam int PW = cdb_payload_w(ROB_IDX_W);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]           ready, push, pop, full, empty;
  logic [NUM_SRC-1:0][PW-1:0]   din, dout;
  logic [NUM_SRC-1:0][CW-1:0]   count;
  logic [2*NUM_SRC-1:0]         req_dbl;
  logic [NUM_SRC-1:0]           req_rot;
  logic [SW-1:0]                rr_ptr, gnt_id;
  logic                         gnt_vld;
  logic [PW-1:0]                gnt_data;
  logic                         live, flush;

  logic                         cdb_flag;
  cdb_src_e                     cdb_src;
  logic [PW-1:0]                cdb_data;

  // Modular add on source ids; base and k are both below NUM_SRC.
  function automatic logic [SW-1:0] rr_add(logic [SW-1:0] base, int unsigned k);
    logic [SW:0] s;
    s = {1'b0, base} + (SW+1)'(k);
    if (s >= (SW+1)'(NUM_SRC)) s = s - (SW+1)'(NUM_SRC);
    return s[SW-1:0];
  endfunction

  assign live  = rdy & ~roll;
  assign flush = rdy & roll;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Readiness looks only at the registered count, never at this cycle's pop.
    assign ready[i] = ~rst & live & (count[i] != CW'(BUF_DEPTH));
    assign push[i]  = bus.src_valid[i] & ready[i];
    assign pop[i]   = live & gnt_vld & (gnt_id == SW'(i));
    assign din[i]   = {bus.src_ROB_idx[i], bus.src_val[i],
                       bus.src_jump_flag[i], bus.src_jump_PC[i]};

    cdb_src_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (PW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .flush (flush),
      .din   (din[i]),
      .dout  (dout[i]),
      .count (count[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push[i] && full[i]));
  end

  assign bus.src_ready = ready;

  // Rotate requests so bit 0 is the source at rr_ptr; the lowest set bit wins.
  assign req_dbl = {~empty, ~empty};
  assign req_rot = NUM_SRC'(req_dbl >> rr_ptr);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = rr_ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_add(rr_ptr, k);
      end
    end
  end

  assign gnt_data = dout[gnt_id];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      cdb_flag <= 1'b0;
      cdb_src  <= CDB_SRC_ALU;
      cdb_data <= '0;
    end else if (flush) begin
      rr_ptr   <= '0;
      cdb_flag <= 1'b0;
    end else if (rdy && gnt_vld) begin
      cdb_flag <= 1'b1;
      cdb_src  <= cdb_src_e'(2'(gnt_id));
      cdb_data <= gnt_data;
      rr_ptr   <= rr_add(gnt_id, 1);
    end else begin
      cdb_flag <= 1'b0;
    end
  end

  assign bus.cdb_flag = cdb_flag;
  assign bus.cdb_src  = cdb_src;
  assign {bus.cdb_ROB_idx, bus.cdb_val, bus.cdb_jump_flag, bus.cdb_jump_PC} = cdb_data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised bench for cdb_arbiter: queue-level reference model feeds a scoreboard
// of expected broadcasts (tagged with their edge); a negedge monitor checks them.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int IW = 4;
  localparam int D  = 2;

  logic clk = 1'b0;
  logic rst, rdy, roll;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_SRC(N), .ROB_IDX_W(IW)) bus ();

  cdb_arbiter #(.NUM_SRC(N), .ROB_IDX_W(IW), .BUF_DEPTH(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .roll (roll),
    .bus  (bus.slave)
  );

  typedef struct { logic [IW-1:0] idx; logic [31:0] val; logic jf; logic [31:0] jpc; } ent_t;
  typedef struct { int tag; int src; ent_t e; } exp_t;

  ent_t         mq[N][$];
  exp_t         sb[$];
  int           rr;
  int           edge_cnt = 0;
  int           n_cmp = 0, n_bad = 0;
  ent_t         cur[N];
  logic [N-1:0] vin;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.src_valid[i]     = vin[i];
      bus.src_ROB_idx[i]   = cur[i].idx;
      bus.src_val[i]       = cur[i].val;
      bus.src_jump_flag[i] = cur[i].jf;
      bus.src_jump_PC[i]   = cur[i].jpc;
    end
  endtask

  task automatic rand_payload(int i);
    cur[i].idx = IW'($urandom);
    cur[i].val = $urandom;
    cur[i].jf  = 1'($urandom_range(0, 1));
    cur[i].jpc = $urandom;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    rr = 0;
    sb.delete();
  endtask

  // Called just after a negedge: drive, check readiness, predict the next edge.
  task automatic cycle();
    logic [N-1:0] er;
    exp_t x;
    int s;
    apply();
    #1;
    for (int i = 0; i < N; i++) er[i] = rdy && !roll && (mq[i].size() != D);
    chk("src_ready", bus.src_ready, er);
    if (rdy && roll) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr = 0;
    end else if (rdy) begin
      for (int k = 0; k < N; k++) begin
        s = (rr + k) % N;
        if (mq[s].size() > 0) begin
          x.tag = edge_cnt + 1;
          x.src = s;
          x.e   = mq[s].pop_front();
          sb.push_back(x);
          rr = (s + 1) % N;
          break;
        end
      end
      for (int i = 0; i < N; i++) if (vin[i] && er[i]) mq[i].push_back(cur[i]);
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    vin = '0;
    repeat (n) cycle();
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (!rst) begin
      if (bus.cdb_flag) begin
        if (sb.size() == 0) begin
          chk("spurious_cdb", bus.cdb_flag, 1'b0);
        end else begin
          x = sb.pop_front();
          chk("cdb_edge", edge_cnt, x.tag);
          chk("cdb_data",
              {bus.cdb_src, bus.cdb_ROB_idx, bus.cdb_val, bus.cdb_jump_flag, bus.cdb_jump_PC},
              {2'(x.src), x.e.idx, x.e.val, x.e.jf, x.e.jpc});
        end
      end else if (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
        x = sb.pop_front();
        chk("cdb_missing", bus.cdb_flag, 1'b1);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    rdy  = 1'b0;
    roll = 1'b0;
    vin  = '0;
    for (int i = 0; i < N; i++) cur[i] = '{default: '0};
    apply();
    repeat (2) @(negedge clk);
    rdy = 1'b1;
    vin = '1;
    apply();
    #1;
    chk("rst_cdb_flag", bus.cdb_flag, 1'b0);
    chk("rst_src_ready", bus.src_ready, '0);
    chk("rst_cdb_val", bus.cdb_val, '0);
    chk("rst_cdb_idx", {bus.cdb_src, bus.cdb_ROB_idx, bus.cdb_jump_flag, bus.cdb_jump_PC}, '0);
    @(negedge clk);
    rst = 1'b0;
    vin = '0;
    model_reset();

    // Single result from the ALU port.
    cur[0] = '{idx: 4'd3, val: 32'h1234, jf: 1'b0, jpc: 32'h0};
    vin = 3'b001;
    cycle();
    idle(3);

    // Clear rr_ptr, then every source pushes every cycle.
    roll = 1'b1; idle(1); roll = 1'b0;
    for (int c = 0; c < 24; c++) begin
      vin = '1;
      for (int i = 0; i < N; i++) rand_payload(i);
      cycle();
    end
    idle(8);

    // LSB port: 5 then 6 while others compete, third push meets a full FIFO.
    roll = 1'b1; idle(1); roll = 1'b0;
    vin = '1;
    for (int i = 0; i < N; i++) rand_payload(i);
    cur[1].idx = 4'd5; cycle();
    cur[1].idx = 4'd6; cycle();
    cur[1].idx = 4'd7; repeat (3) cycle();
    idle(8);

    // Roll with results buffered in src0 and src2, pushes in the roll cycle dropped.
    vin = 3'b101;
    for (int c = 0; c < 2; c++) begin
      rand_payload(0); rand_payload(2); cycle();
    end
    vin = '1; roll = 1'b1; cycle(); roll = 1'b0;
    idle(6);

    // Freeze with one entry waiting; roll during freeze is ignored.
    rand_payload(0); vin = 3'b001; cycle();
    vin = '0; rdy = 1'b0;
    cycle(); roll = 1'b1; cycle(); roll = 1'b0; cycle();
    rdy = 1'b1;
    idle(4);

    // Random traffic with occasional freezes and rolls.
    for (int c = 0; c < 1500; c++) begin
      rdy  = ($urandom_range(0, 9) != 0);
      roll = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        vin[i] = ($urandom_range(0, 9) < 7);
        rand_payload(i);
      end
      cycle();
    end
    rdy = 1'b1; roll = 1'b0;
    idle(8);

    // Asynchronous reset in the middle of a burst.
    for (int c = 0; c < 5; c++) begin
      vin = '1;
      for (int i = 0; i < N; i++) rand_payload(i);
      cycle();
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cdb_flag", bus.cdb_flag, 1'b0);
    chk("async_rst_src_ready", bus.src_ready, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(10);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
